// File: rtl/misc_v_pkg.sv
// Shared encodings for the instruction encoder: opcodes, control-field values,
// instruction field positions, the control bundle type and the session FSM states.
package misc_v_pkg;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_I    = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;
  localparam logic [2:0] OP_JIN  = 3'd6;
  localparam logic [2:0] OP_JOUT = 3'd7;

  localparam logic [2:0] ALUOP_0 = 3'd0;
  localparam logic [2:0] ALUOP_1 = 3'd1;
  localparam logic [2:0] ALUOP_2 = 3'd2;
  localparam logic [2:0] ALUOP_3 = 3'd3;
  localparam logic [2:0] ALUOP_4 = 3'd4;
  localparam logic [2:0] ALUOP_5 = 3'd5;
  localparam logic [2:0] ALUOP_6 = 3'd6;
  localparam logic [2:0] ALUOP_7 = 3'd7;

  localparam logic [1:0] RS_NONE = 2'd0;
  localparam logic [1:0] RS_ALU  = 2'd1;
  localparam logic [1:0] RS_LINK = 2'd2;
  localparam logic [1:0] RS_RSVD = 2'd3;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int FUNC_MSB = 12;
  localparam int FUNC_LSB = 9;
  localparam int OPND_MSB = 8;
  localparam int OPND_LSB = 0;
  localparam int INSTR_W  = 16;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic [2:0] aluop;
    logic       memwrite;
    logic       memread;
    logic [1:0] regstore;
    logic       branch;
    logic       jumpout;
    logic       ne;
    logic [1:0] funclo;
    logic [8:0] operand;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encode_comb.sv
// Pure combinational inverse of the Control decoder: control bundle -> {legal, word}.
// Rules are prioritised; the first matching rule defines the encoding.
module instr_encode_comb
  import misc_v_pkg::*;
(
  input  ctrl_t               ctrl_i,
  output logic                legal_o,
  output logic [INSTR_W-1:0]  word_o
);

  logic [2:0] opc;
  logic [3:0] func;
  logic [1:0] isel;

  always_comb begin
    opc     = OP_R;
    func    = 4'd0;
    isel    = 2'd0;
    legal_o = 1'b1;
    if (ctrl_i.branch && ctrl_i.jumpout && ctrl_i.aluop == ALUOP_0) begin
      opc = OP_JOUT;
    end else if (ctrl_i.branch && ctrl_i.regstore == RS_LINK && ctrl_i.aluop == ALUOP_0) begin
      opc = OP_JIN;
    end else if (ctrl_i.branch && ctrl_i.aluop == ALUOP_2) begin
      opc = ctrl_i.ne ? OP_BNE : OP_BEQ;
    end else if (ctrl_i.memwrite && !ctrl_i.regwrite && ctrl_i.aluop == ALUOP_1 && !ctrl_i.alusrc) begin
      opc = OP_SW;
    end else if (ctrl_i.memread && ctrl_i.regwrite && ctrl_i.aluop == ALUOP_1 && !ctrl_i.alusrc) begin
      opc = OP_LW;
    end else if (ctrl_i.regwrite && ctrl_i.alusrc && ctrl_i.regstore == RS_ALU &&
                 ctrl_i.aluop >= ALUOP_1 && ctrl_i.aluop <= ALUOP_4) begin
      opc  = OP_R;
      func = {1'b0, ctrl_i.aluop - 3'd1};
    end else if (ctrl_i.regwrite && !ctrl_i.alusrc && ctrl_i.regstore == RS_ALU) begin
      // I-type ALU ops are sparse in ALUOp; squeeze them into a 2-bit selector.
      opc = OP_I;
      case (ctrl_i.aluop)
        ALUOP_1: isel = 2'd0;
        ALUOP_5: isel = 2'd1;
        ALUOP_6: isel = 2'd2;
        ALUOP_7: isel = 2'd3;
        default: legal_o = 1'b0;
      endcase
      func = {isel, ctrl_i.funclo};
    end else begin
      legal_o = 1'b0;
    end
  end

  assign word_o = {opc, func, ctrl_i.operand};

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction memory loader: encodes control-level requests and
// writes them to auto-incrementing addresses with a held write strobe until ack.
module instr_encoder
  import misc_v_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LIMIT  = 256
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_regwrite,
  input  logic                req_alusrc,
  input  logic [2:0]          req_aluop,
  input  logic                req_memwrite,
  input  logic                req_memread,
  input  logic [1:0]          req_regstore,
  input  logic                req_branch,
  input  logic                req_jumpout,
  input  logic                req_ne,
  input  logic [1:0]          req_funclo,
  input  logic [8:0]          req_operand,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  input  logic                imem_ack,
  output logic                illegal,
  output logic                err,
  output logic                full,
  output logic [ADDR_W:0]     count
);

  localparam logic [ADDR_W:0] LIMIT_C = LIMIT[ADDR_W:0];

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [ADDR_W:0]      count_inc;
  logic                 err_q, err_d;
  logic                 illegal_q, illegal_d;
  logic                 stop_seen_q, stop_seen_d;

  ctrl_t                ctrl;
  logic                 enc_legal;
  logic [INSTR_W-1:0]   enc_word;
  logic                 hs;

  assign ctrl = '{regwrite: req_regwrite, alusrc: req_alusrc, aluop: req_aluop,
                  memwrite: req_memwrite, memread: req_memread, regstore: req_regstore,
                  branch: req_branch, jumpout: req_jumpout, ne: req_ne,
                  funclo: req_funclo, operand: req_operand};

  instr_encode_comb u_enc (
    .ctrl_i  (ctrl),
    .legal_o (enc_legal),
    .word_o  (enc_word)
  );

  assign hs        = req_valid && (state_q == ST_READY);
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    illegal_d   = 1'b0;
    stop_seen_d = stop_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READY;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_READY: begin
        if (hs) begin
          if (enc_legal) begin
            wdata_d     = enc_word;
            state_d     = ST_WRITE;
            stop_seen_d = stop;
          end else begin
            illegal_d = 1'b1;
            err_d     = 1'b1;
            if (stop) state_d = ST_IDLE;
          end
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // A stop during a write is deferred until the ack retires the word.
        if (stop) stop_seen_d = 1'b1;
        if (imem_ack) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_inc;
          if (count_inc == LIMIT_C)       state_d = ST_FULL;
          else if (stop_seen_q || stop)   state_d = ST_IDLE;
          else                            state_d = ST_READY;
        end
      end
      ST_FULL: begin
        if (start) begin
          state_d = ST_READY;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      illegal_q   <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      illegal_q   <= illegal_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign req_ready  = (state_q == ST_READY);
  assign imem_we    = (state_q == ST_WRITE);
  assign full       = (state_q == ST_FULL);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign illegal    = illegal_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scenario tasks drive requests and act as
// the instruction memory; expected address/word pairs flow through a scoreboard.
module tb_instr_encoder;

  localparam int ADDR_W = 8;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_regwrite = 1'b0;
  logic              req_alusrc = 1'b0;
  logic [2:0]        req_aluop = '0;
  logic              req_memwrite = 1'b0;
  logic              req_memread = 1'b0;
  logic [1:0]        req_regstore = '0;
  logic              req_branch = 1'b0;
  logic              req_jumpout = 1'b0;
  logic              req_ne = 1'b0;
  logic [1:0]        req_funclo = '0;
  logic [8:0]        req_operand = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              imem_ack = 1'b0;
  logic              illegal;
  logic              err;
  logic              full;
  logic [ADDR_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] sb_addr[$];
  logic [15:0]       sb_data[$];

  always #5 CLK = ~CLK;

  instr_encoder #(.ADDR_W(ADDR_W), .LIMIT(4)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stop(stop), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_regwrite(req_regwrite), .req_alusrc(req_alusrc), .req_aluop(req_aluop),
    .req_memwrite(req_memwrite), .req_memread(req_memread), .req_regstore(req_regstore),
    .req_branch(req_branch), .req_jumpout(req_jumpout), .req_ne(req_ne),
    .req_funclo(req_funclo), .req_operand(req_operand),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
    .illegal(illegal), .err(err), .full(full), .count(count)
  );

  task automatic set_req(input logic rw, input logic as, input logic [2:0] op,
                         input logic mw, input logic mr, input logic [1:0] rs,
                         input logic br, input logic jo, input logic ne,
                         input logic [1:0] fl, input logic [8:0] opnd);
    req_regwrite = rw; req_alusrc = as; req_aluop = op; req_memwrite = mw;
    req_memread = mr; req_regstore = rs; req_branch = br; req_jumpout = jo;
    req_ne = ne; req_funclo = fl; req_operand = opnd;
  endtask

  // Handshake one request; a legal one is queued with the address it must land at.
  task automatic do_handshake(input bit legal, input logic [15:0] w);
    @(negedge CLK);
    req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_before_hs: got %b want 1", req_ready); n_fail++;
    end
    if (legal) begin
      sb_addr.push_back(exp_addr);
      sb_data.push_back(w);
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Act as memory: wait for the strobe, check against the scoreboard, ack after 'hold'.
  task automatic do_write(input int hold, input bit stop_mid);
    int waited = 0;
    logic [ADDR_W-1:0] ea;
    logic [15:0] ed;
    @(negedge CLK);
    while (imem_we !== 1'b1 && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (imem_we !== 1'b1) begin
      $display("FAIL we_timeout: imem_we=%b after %0d cycles, want 1", imem_we, waited);
      n_fail++;
      return;
    end
    n_checks++;
    if (sb_addr.size() == 0) begin
      $display("FAIL sb_unexpected_write: addr=%h data=%h with empty scoreboard", imem_addr, imem_wdata);
      n_fail++;
      return;
    end
    ea = sb_addr.pop_front();
    ed = sb_data.pop_front();
    n_checks++;
    if (imem_addr !== ea) begin
      $display("FAIL wr_addr: got %h want %h", imem_addr, ea); n_fail++;
    end
    n_checks++;
    if (imem_wdata !== ed) begin
      $display("FAIL wr_data: got %h want %h", imem_wdata, ed); n_fail++;
    end
    for (int i = 0; i < hold; i++) begin
      if (stop_mid && i == 1) stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      n_checks++;
      if (imem_we !== 1'b1 || imem_wdata !== ed || imem_addr !== ea) begin
        $display("FAIL wr_hold: we=%b addr=%h data=%h want 1 %h %h", imem_we, imem_addr, imem_wdata, ea, ed);
        n_fail++;
      end
    end
    imem_ack = 1'b1;
    @(negedge CLK);
    imem_ack = 1'b0;
    n_checks++;
    if (imem_we !== 1'b0) begin
      $display("FAIL we_drop: got %b want 0", imem_we); n_fail++;
    end
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] base);
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    start = 1'b1;
    base_addr = base;
    @(negedge CLK);
    start = 1'b0;
    exp_addr = base;
    n_checks++;
    if (imem_addr !== base || count !== '0 || req_ready !== 1'b1 || err !== 1'b0) begin
      $display("FAIL session_start: addr=%h count=%0d ready=%b err=%b want %h 0 1 0",
               imem_addr, count, req_ready, err, base);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++;
    if ({req_ready, imem_we, illegal, err, full} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000", {req_ready, imem_we, illegal, err, full}); n_fail++;
    end
    n_checks++;
    if (imem_addr !== '0 || imem_wdata !== '0 || count !== '0) begin
      $display("FAIL reset_regs: addr=%h data=%h count=%0d want 0", imem_addr, imem_wdata, count); n_fail++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    begin_session(8'h10);
    set_req(1, 1, 3'd3, 0, 0, 2'd1, 0, 0, 0, 2'd0, 9'h012);
    do_handshake(1, 16'h0412);
    do_write(0, 0);
    n_checks++;
    if (count !== 9'd1 || imem_addr !== 8'h11 || req_ready !== 1'b1) begin
      $display("FAIL rtype_after: count=%0d addr=%h ready=%b want 1 11 1", count, imem_addr, req_ready); n_fail++;
    end
  endtask

  task automatic test_itype_bne();
    begin_session(8'h20);
    set_req(1, 0, 3'd6, 0, 0, 2'd1, 0, 0, 0, 2'd1, 9'h005);
    do_handshake(1, 16'h3205);
    do_write(0, 0);
    set_req(0, 0, 3'd2, 0, 0, 2'd0, 1, 0, 1, 2'd0, 9'h1F0);
    do_handshake(1, 16'hA1F0);
    do_write(0, 0);
    n_checks++;
    if (count !== 9'd2 || imem_addr !== 8'h22) begin
      $display("FAIL itype_bne_count: count=%0d addr=%h want 2 22", count, imem_addr); n_fail++;
    end
  endtask

  task automatic test_jumps_illegal();
    begin_session(8'h30);
    set_req(0, 0, 3'd0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 9'h000);
    do_handshake(1, 16'hE000);
    do_write(0, 0);
    set_req(0, 0, 3'd0, 0, 0, 2'd2, 1, 0, 0, 2'd0, 9'h0AB);
    do_handshake(1, 16'hC0AB);
    do_write(0, 0);
    set_req(1, 1, 3'd5, 0, 0, 2'd1, 0, 0, 0, 2'd0, 9'h000);
    do_handshake(0, 16'h0000);
    @(negedge CLK);
    n_checks++;
    if (illegal !== 1'b1 || err !== 1'b1 || imem_we !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL illegal_pulse: ill=%b err=%b we=%b ready=%b want 1 1 0 1", illegal, err, imem_we, req_ready);
      n_fail++;
    end
    @(negedge CLK);
    n_checks++;
    if (illegal !== 1'b0 || err !== 1'b1 || count !== 9'd2 || imem_we !== 1'b0) begin
      $display("FAIL illegal_after: ill=%b err=%b count=%0d we=%b want 0 1 2 0", illegal, err, count, imem_we);
      n_fail++;
    end
  endtask

  task automatic test_limit_wrap();
    begin_session(8'hFE);
    set_req(1, 1, 3'd5, 0, 0, 2'd1, 0, 0, 0, 2'd0, 9'h000);
    do_handshake(0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 3'd1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 9'h100 + 9'(i));
      do_handshake(1, 16'h6100 + 16'(i));
      do_write(0, 0);
    end
    n_checks++;
    if (full !== 1'b1 || req_ready !== 1'b0 || count !== 9'd4 || imem_addr !== 8'h02 || err !== 1'b1) begin
      $display("FAIL limit_full: full=%b ready=%b count=%0d addr=%h err=%b want 1 0 4 02 1",
               full, req_ready, count, imem_addr, err);
      n_fail++;
    end
    start = 1'b1;
    base_addr = 8'h40;
    @(negedge CLK);
    start = 1'b0;
    exp_addr = 8'h40;
    n_checks++;
    if (full !== 1'b0 || count !== '0 || err !== 1'b0 || req_ready !== 1'b1 || imem_addr !== 8'h40) begin
      $display("FAIL full_restart: full=%b count=%0d err=%b ready=%b addr=%h want 0 0 0 1 40",
               full, count, err, req_ready, imem_addr);
      n_fail++;
    end
  endtask

  task automatic test_stall_stop();
    begin_session(8'h50);
    set_req(1, 0, 3'd1, 0, 1, 2'd0, 0, 0, 0, 2'd0, 9'h077);
    do_handshake(1, 16'h4077);
    do_write(5, 1);
    n_checks++;
    if (req_ready !== 1'b0 || full !== 1'b0 || count !== 9'd1 || imem_addr !== 8'h51) begin
      $display("FAIL stall_stop_idle: ready=%b full=%b count=%0d addr=%h want 0 0 1 51",
               req_ready, full, count, imem_addr);
      n_fail++;
    end
  endtask

  task automatic test_reset_midwrite();
    begin_session(8'h60);
    set_req(0, 0, 3'd2, 0, 0, 2'd0, 1, 0, 0, 2'd0, 9'h033);
    do_handshake(1, 16'h8033);
    @(negedge CLK);
    n_checks++;
    if (imem_we !== 1'b1 || imem_wdata !== 16'h8033) begin
      $display("FAIL pre_reset_write: we=%b data=%h want 1 8033", imem_we, imem_wdata); n_fail++;
    end
    sb_addr.delete();
    sb_data.delete();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, imem_we, illegal, err, full} !== 5'b0 || imem_addr !== '0 || imem_wdata !== '0 || count !== '0) begin
      $display("FAIL async_reset: flags=%b addr=%h data=%h count=%0d want all 0",
               {req_ready, imem_we, illegal, err, full}, imem_addr, imem_wdata, count);
      n_fail++;
    end
    @(negedge CLK);
    reset = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if (imem_we !== 1'b0 || req_ready !== 1'b0 || count !== '0) begin
        $display("FAIL ignore_after_reset: we=%b ready=%b count=%0d want 0 0 0", imem_we, req_ready, count);
        n_fail++;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    exp_addr = '0;
    test_reset();
    test_rtype();
    test_itype_bne();
    test_jumps_illegal();
    test_limit_wrap();
    test_stall_stop();
    test_reset_midwrite();
    n_checks++;
    if (sb_addr.size() != 0) begin
      $display("FAIL sb_leftover: %0d entries want 0", sb_addr.size()); n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
